matrix_result_streamer: RTL and testbench
=========================================

# matrix_result_streamer

Downstream stage of `matrix_mult_128x128`. On the multiplier's `done`, the block snapshots the flattened N×N result bus. It then streams the elements out one per cycle in row-major order over a valid/ready handshake, each tagged with its row/column index. Each element is optionally arithmetic-shifted and saturated to a narrower width. Because of the snapshot, the multiplier is free to restart as soon as capture completes.

## Interface
- `N`, 128, matrix dimension (rows = cols = N)
- `DATA_W`, 16, element width on `result_flat`, signed two's complement
- `OUT_W`, 16, output element width; must satisfy `OUT_W <= DATA_W`
- `SHIFT`, 0, arithmetic right shift applied before saturation; range 0..DATA_W-1
- Index width `IDX_W = $clog2(N)`, local

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mm_done`  in  1  done from the multiplier; level or pulse
- `result_flat`  in  N*N*DATA_W  element (r,c) at bits `[(r*N+c)*DATA_W +: DATA_W]`
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  sink accepts the beat
- `out_data`  out  OUT_W  shifted/saturated element
- `out_row`  out  IDX_W  row index of beat
- `out_col`  out  IDX_W  column index of beat
- `out_last`  out  1  high on beat (N-1,N-1)
- `out_sat`  out  1  high when this beat was clamped
- `busy`  out  1  snapshot held, streaming in progress
- `drop`  out  1  sticky: a `done` rising edge was ignored while busy
- `clear_drop`  in  1  synchronous clear of `drop`

## Operation
- Edge detect:
  - `done_q` is `mm_done` registered; `rise = mm_done & ~done_q`.
  - If `mm_done` is already high at reset release, that counts as one rise.
  - Holding `mm_done` high produces exactly one rise.
- States:
  - IDLE → STREAM on `rise`. At that edge the whole of `result_flat` is copied into the internal snapshot and the row/col counters are set to 0.
  - STREAM holds while beats remain.
  - STREAM → IDLE on the handshake (`out_valid & out_ready`) of the beat with `out_last=1`.
- Order:
  - Row-major, (0,0), (0,1) … (0,N-1), (1,0) … (N-1,N-1).
  - Column counter wraps N-1→0 and increments the row counter.
  - Exactly N*N beats per capture.
- Arithmetic:
  - `t = $signed(elem) >>> SHIFT`.
  - If `t > 2^(OUT_W-1)-1`: `out_data = 2^(OUT_W-1)-1`, `out_sat=1`.
  - If `t < -2^(OUT_W-1)`: `out_data = -2^(OUT_W-1)`, `out_sat=1`.
  - Otherwise `out_data = t[OUT_W-1:0]`, `out_sat=0`.
  - Defaults (`OUT_W=DATA_W`, `SHIFT=0`) give a bit-exact passthrough.
- Drop:
  - A `rise` in STREAM is ignored and sets `drop`. This includes the cycle of the final handshake.
  - The snapshot is never modified while in STREAM, whatever `result_flat` does.
  - `clear_drop` clears `drop`; if `clear_drop` and a drop event occur in the same cycle, set wins.
- Reset mid-operation:
  - All state is forced to IDLE immediately (asynchronous).
  - Counters, `drop` and `done_q` are cleared. Snapshot contents are don't-care.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_row=0`, `out_col=0`, `out_last=0`, `out_sat=0`, `busy=0`, `drop=0`.
- Capture latency: with `rise` sampled at edge k, `out_valid` and `busy` are high after edge k, and the first beat (0,0) is presented in cycle k+1.
- Beat outputs (`out_data`, `out_row`, `out_col`, `out_last`, `out_sat`) come from registers. There is no combinational path from `out_ready` to any output.
- Handshake rules:
  - A beat transfers on an edge where `out_valid & out_ready`.
  - While `out_valid & ~out_ready`, all beat outputs hold stable.
  - `out_valid` never drops without a transfer.
- Throughput: one beat per cycle with `out_ready` held high. A full stream takes N*N cycles from first presentation.
- `busy` equals (state == STREAM).
- After the final transfer, `out_valid`, `out_last` and `busy` are low in the next cycle. The earliest new capture is at the edge following the return to IDLE.
- Outside STREAM, `out_data`, `out_sat`, `out_row` and `out_col` return to 0.

## Test plan
- N=4, all-0x0001 result, `out_ready=1`, `mm_done` pulsed once:
  - 16 consecutive beats of 0x0001 with (row,col) from (0,0) to (3,3).
  - `out_last` only on beat 16.
  - `busy` high for exactly 16 cycles, `drop=0`.
- N=4, result (r,c) = r*4+c, `out_ready` pseudo-random at 50%:
  - Values 0..15 arrive in order with none lost or duplicated.
  - All beat outputs are stable on every stalled cycle.
- N=4, `OUT_W=8`, `SHIFT=4`, elements 0x7FFF, 0x8000, 0x0120, 0xFFF0:
  - Outputs are 0x7F/sat=1, 0x80/sat=1, 0x12/sat=0, 0xFF/sat=0.
- `mm_done` pulsed again at beat 5, with `result_flat` changed at the same time:
  - The stream still delivers the original snapshot and `drop=1`.
  - One cycle of `clear_drop` returns `drop` to 0.
  - A `done` in the final-handshake cycle is also dropped.
- `mm_done` held high for 100 cycles: exactly one capture of N*N beats, and no drop while the level stays high.
- `rst_n` asserted low mid-cycle at beat 7:
  - All outputs go to their reset values immediately.
  - After release, a new `mm_done` yields a complete stream starting at (0,0).
- Default parameters (N=128), identity × all-ones from the multiplier:
  - 16384 beats of 0x0001.
  - `out_last` on (127,127).

Source files
------------

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_result_streamer
//  Purpose  : Snapshots the N x N result bus of the matrix multiplier on a
//             rising edge of mm_done, then streams the elements row-major
//             over a valid/ready handshake. Each beat carries its (row, col)
//             index. The element is arithmetic-shifted right by SHIFT and
//             saturated to OUT_W bits.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_result_streamer #(
  parameter int N      = 128,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mm_done,
  input  logic [N*N*DATA_W-1:0]   result_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_row,
  output logic [IDX_W-1:0]        out_col,
  output logic                    out_last,
  output logic                    out_sat,
  output logic                    busy,
  output logic                    drop,
  input  logic                    clear_drop
);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_stream = 1'b1;

  localparam int c_elem_w = $clog2(N * N);

  // Saturation bounds, one bit wider than DATA_W so OUT_W == DATA_W never clips.
  localparam logic signed [DATA_W:0] c_sat_max =
    {{(DATA_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [DATA_W:0] c_sat_min =
    {{(DATA_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Shift then clamp one element; returns {saturated, data}.
  function automatic logic [OUT_W:0] f_shape(input logic [DATA_W-1:0] elem);
    logic signed [DATA_W-1:0] t;
    logic signed [DATA_W:0]   tx;
    t  = $signed(elem) >>> SHIFT;
    tx = {t[DATA_W-1], t};
    if (tx > c_sat_max) begin
      f_shape = {1'b1, c_sat_max[OUT_W-1:0]};
    end else if (tx < c_sat_min) begin
      f_shape = {1'b1, c_sat_min[OUT_W-1:0]};
    end else begin
      f_shape = {1'b0, t[OUT_W-1:0]};
    end
  endfunction

  logic [0:0]                   r_state;
  logic                         r_done_q;
  logic                         r_drop;
  logic [IDX_W-1:0]             r_row;
  logic [IDX_W-1:0]             r_col;
  logic [OUT_W-1:0]             r_data;
  logic                         r_sat;
  logic                         r_last;
  logic [N*N-1:0][DATA_W-1:0]   r_snap;

  logic                         w_rise;
  logic                         w_xfer;
  logic                         w_col_wrap;
  logic [IDX_W-1:0]             w_next_row;
  logic [IDX_W-1:0]             w_next_col;
  logic                         w_next_last;
  logic [c_elem_w-1:0]          w_next_idx;
  logic [OUT_W:0]               w_next_shaped;
  logic [OUT_W:0]               w_first_shaped;

  // Edge detect, handshake and next-beat index/element selection.
  always_comb begin
    w_rise         = mm_done & ~r_done_q;
    w_xfer         = (r_state == c_st_stream) & out_ready;
    w_col_wrap     = (r_col == IDX_W'(N - 1));
    w_next_col     = w_col_wrap ? '0 : r_col + IDX_W'(1);
    w_next_row     = w_col_wrap ? r_row + IDX_W'(1) : r_row;
    w_next_last    = (w_next_row == IDX_W'(N - 1)) && (w_next_col == IDX_W'(N - 1));
    w_next_idx     = c_elem_w'(32'(w_next_row) * 32'(N) + 32'(w_next_col));
    w_next_shaped  = f_shape(r_snap[w_next_idx]);
    // First beat is taken straight from the bus since the snapshot loads on the same edge.
    w_first_shaped = f_shape(result_flat[DATA_W-1:0]);
  end

  // Snapshot register: loaded only on the capturing edge, untouched while streaming.
  always_ff @(posedge clk) begin
    if ((r_state == c_st_idle) && w_rise) begin
      r_snap <= result_flat;
    end
  end

  // Control FSM, beat output registers and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_done_q <= 1'b0;
      r_drop   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_data   <= '0;
      r_sat    <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_done_q <= mm_done;

      // A new result arriving while one is still being streamed is lost; set beats clear.
      if (w_rise && (r_state == c_st_stream)) begin
        r_drop <= 1'b1;
      end else if (clear_drop) begin
        r_drop <= 1'b0;
      end

      case (r_state)
        c_st_idle: begin
          if (w_rise) begin
            r_state <= c_st_stream;
            r_row   <= '0;
            r_col   <= '0;
            r_sat   <= w_first_shaped[OUT_W];
            r_data  <= w_first_shaped[OUT_W-1:0];
            r_last  <= (N == 1);
          end
        end
        c_st_stream: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= c_st_idle;
              r_row   <= '0;
              r_col   <= '0;
              r_sat   <= 1'b0;
              r_data  <= '0;
              r_last  <= 1'b0;
            end else begin
              r_row   <= w_next_row;
              r_col   <= w_next_col;
              r_sat   <= w_next_shaped[OUT_W];
              r_data  <= w_next_shaped[OUT_W-1:0];
              r_last  <= w_next_last;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign out_valid = (r_state == c_st_stream);
  assign busy      = (r_state == c_st_stream);
  assign out_data  = r_data;
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_last  = r_last;
  assign out_sat   = r_sat;
  assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_result_streamer
//  Purpose  : Directed bench for matrix_result_streamer: N=4 passthrough,
//             N=4 shift/saturate table, and a full N=128 stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: N=4 passthrough
  logic          done_a, rdy_a, clr_a;
  logic [255:0]  res_a;
  logic          valid_a, last_a, sat_a, busy_a, drop_a;
  logic [15:0]   data_a;
  logic [1:0]    row_a, col_a;

  // Instance B: N=4, OUT_W=8, SHIFT=4
  logic          done_b, rdy_b, clr_b;
  logic [255:0]  res_b;
  logic          valid_b, last_b, sat_b, busy_b, drop_b;
  logic [7:0]    data_b;
  logic [1:0]    row_b, col_b;

  // Instance C: default N=128
  logic                  done_c, rdy_c, clr_c;
  logic [128*128*16-1:0] res_c;
  logic                  valid_c, last_c, sat_c, busy_c, drop_c;
  logic [15:0]           data_c;
  logic [6:0]            row_c, col_c;

  matrix_result_streamer #(.N(4), .DATA_W(16), .OUT_W(16), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .mm_done(done_a), .result_flat(res_a),
    .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .out_row(row_a),
    .out_col(col_a), .out_last(last_a), .out_sat(sat_a), .busy(busy_a),
    .drop(drop_a), .clear_drop(clr_a));

  matrix_result_streamer #(.N(4), .DATA_W(16), .OUT_W(8), .SHIFT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mm_done(done_b), .result_flat(res_b),
    .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b), .out_row(row_b),
    .out_col(col_b), .out_last(last_b), .out_sat(sat_b), .busy(busy_b),
    .drop(drop_b), .clear_drop(clr_b));

  matrix_result_streamer dut_c (
    .clk(clk), .rst_n(rst_n), .mm_done(done_c), .result_flat(res_c),
    .out_valid(valid_c), .out_ready(rdy_c), .out_data(data_c), .out_row(row_c),
    .out_col(col_c), .out_last(last_c), .out_sat(sat_c), .busy(busy_c),
    .drop(drop_c), .clear_drop(clr_c));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] elem;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } sat_vec_t;

  sat_vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pack_a();
    return {valid_a, last_a, sat_a, busy_a, row_a, col_a, data_a};
  endfunction

  function automatic logic [23:0] beat_a(input int i, input logic [15:0] d);
    return {1'b1, (i == 15), 1'b0, 1'b1, 2'(i / 4), 2'(i % 4), d};
  endfunction

  task automatic fill_a_index();
    for (int i = 0; i < 16; i++) res_a[i*16 +: 16] = 16'(i);
  endtask

  // Full 16-beat stream on instance A with out_ready held high.
  task automatic stream_check_a(input string tag, input bit count_mode);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_beat"}, pack_a(), beat_a(i, count_mode ? 16'(i) : 16'h0001));
      step();
    end
    chk({tag, "_end"}, {valid_a, last_a, busy_a}, 3'b000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int idx, nb, nbusy, bad, nlast;
    logic        stall;
    logic [23:0] saved;

    vecs[0]  = '{16'h7FFF, 8'h7F, 1'b1};
    vecs[1]  = '{16'h8000, 8'h80, 1'b1};
    vecs[2]  = '{16'h0120, 8'h12, 1'b0};
    vecs[3]  = '{16'hFFF0, 8'hFF, 1'b0};
    vecs[4]  = '{16'h07F0, 8'h7F, 1'b0};
    vecs[5]  = '{16'h07FF, 8'h7F, 1'b0};
    vecs[6]  = '{16'h0800, 8'h7F, 1'b1};
    vecs[7]  = '{16'hF800, 8'h80, 1'b0};
    vecs[8]  = '{16'hF7FF, 8'h80, 1'b1};
    vecs[9]  = '{16'h0000, 8'h00, 1'b0};
    vecs[10] = '{16'h000F, 8'h00, 1'b0};
    vecs[11] = '{16'hFFFF, 8'hFF, 1'b0};
    vecs[12] = '{16'h0010, 8'h01, 1'b0};
    vecs[13] = '{16'hFFE0, 8'hFE, 1'b0};
    vecs[14] = '{16'h1234, 8'h7F, 1'b1};
    vecs[15] = '{16'hEDCC, 8'h80, 1'b1};

    rst_n = 1'b0;
    done_a = 0; rdy_a = 0; clr_a = 0; res_a = '0;
    done_b = 0; rdy_b = 0; clr_b = 0; res_b = '0;
    done_c = 0; rdy_c = 0; clr_c = 0; res_c = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    chk("rst_a", pack_a(), 24'h0);
    chk("rst_drop_a", drop_a, 1'b0);
    chk("rst_b", {valid_b, busy_b, data_b, sat_b, row_b, col_b, last_b, drop_b}, 0);
    chk("rst_c", {valid_c, busy_c, data_c, sat_c, row_c, col_c, last_c, drop_c}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_a", pack_a(), 24'h0);

    // T1: all-ones, ready high, single pulse
    for (int i = 0; i < 16; i++) res_a[i*16 +: 16] = 16'h0001;
    rdy_a = 1'b1;
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    stream_check_a("t1", 1'b0);
    chk("t1_drop", drop_a, 1'b0);

    // T2: index pattern, random ready, stability on stalls
    fill_a_index();
    rdy_a = 1'b0;
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    idx = 0; stall = 1'b0; saved = '0;
    for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
      if (stall) chk("t2_stable", pack_a(), saved);
      rdy_a = 1'($urandom_range(0, 1));
      if (valid_a && rdy_a) begin
        chk("t2_beat", pack_a(), beat_a(idx, 16'(idx)));
        idx++;
        stall = 1'b0;
      end else begin
        stall = valid_a;
        saved = pack_a();
      end
      step();
    end
    chk("t2_count", idx, 16);
    chk("t2_end", {valid_a, busy_a}, 2'b00);
    rdy_a = 1'b1;

    // T3: done during stream (with bus change), clear, and done on final handshake
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t3_beat", pack_a(), beat_a(i, 16'(i)));
      if (i == 5) begin
        done_a = 1'b1;
        clr_a = 1'b1;
        for (int k = 0; k < 16; k++) res_a[k*16 +: 16] = 16'hAAAA;
      end
      if (i == 6) begin
        done_a = 1'b0;
        clr_a = 1'b0;
        chk("t3_drop_set", drop_a, 1'b1);
      end
      if (i == 9) clr_a = 1'b1;
      if (i == 10) begin
        clr_a = 1'b0;
        chk("t3_drop_clr", drop_a, 1'b0);
      end
      if (i == 15) done_a = 1'b1;
      step();
    end
    chk("t3_end", {valid_a, busy_a, drop_a}, 3'b001);
    done_a = 1'b0;
    step();
    step();
    chk("t3_no_capture", {valid_a, busy_a}, 2'b00);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("t3_drop_final_clr", drop_a, 1'b0);

    // T4: done held high for 100 cycles
    fill_a_index();
    nb = 0; nbusy = 0;
    done_a = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (busy_a) nbusy++;
      if (valid_a) begin
        if (nb < 16) chk("t4_beat", pack_a(), beat_a(nb, 16'(nb)));
        nb++;
      end
    end
    done_a = 1'b0;
    step();
    chk("t4_beats", nb, 16);
    chk("t4_busy_cycles", nbusy, 16);
    chk("t4_drop", drop_a, 1'b0);
    chk("t4_end", {valid_a, busy_a}, 2'b00);

    // T5: asynchronous reset at beat 7, mm_done high across release
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    repeat (7) step();
    chk("t5_at7", pack_a(), beat_a(7, 16'd7));
    #2;
    rst_n = 1'b0;
    done_a = 1'b1;
    #1;
    chk("t5_async_rst", pack_a(), 24'h0);
    chk("t5_rst_drop", drop_a, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    done_a = 1'b0;
    stream_check_a("t5", 1'b1);

    // T6: shift/saturate table on instance B
    for (int i = 0; i < 16; i++) res_b[i*16 +: 16] = vecs[i].elem;
    rdy_b = 1'b1;
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t6_sat_beat", {valid_b, sat_b, data_b, row_b, col_b, last_b},
          {1'b1, vecs[i].exp_sat, vecs[i].exp_data, 2'(i / 4), 2'(i % 4), (i == 15)});
      step();
    end
    chk("t6_end", {valid_b, busy_b, data_b, sat_b}, 0);

    // T7: N=128 all-ones stream
    for (int i = 0; i < 128 * 128; i++) res_c[i*16 +: 16] = 16'h0001;
    rdy_c = 1'b1;
    done_c = 1'b1;
    step();
    done_c = 1'b0;
    nb = 0; bad = 0; nlast = 0;
    for (int cyc = 0; cyc < 17000 && nb < 16384; cyc++) begin
      if (valid_c) begin
        if (data_c !== 16'h0001 || sat_c !== 1'b0 || row_c !== 7'(nb / 128) ||
            col_c !== 7'(nb % 128) || last_c !== (nb == 16383)) bad++;
        if (last_c) nlast++;
        nb++;
      end
      step();
    end
    chk("t7_beats", nb, 16384);
    chk("t7_bad_beats", bad, 0);
    chk("t7_last_count", nlast, 1);
    chk("t7_end", {valid_c, busy_c, last_c, drop_c}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
